// File: rtl/lfsr_step_ctrl.sv
// LFSR state register with seed load, free-run/pause FSM and period measurement.
// The per-bit seed/feedback select is generated here and presented as a registered output.
module lfsr_step_ctrl #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
    parameter int               CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             run,
    output logic [WIDTH-1:0] q,
    output logic             sel,
    output logic             running,
    output logic             period_done,
    output logic [CW-1:0]    period,
    output logic             seed_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  seed_cap_r;
    logic [WIDTH-1:0]  q_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_inc_s;
    logic [CW-1:0]     period_r;
    logic              sel_r;
    logic              running_r;
    logic              period_done_r;
    logic              seed_err_r;
    logic              load_ok_s;
    logic              load_bad_s;
    logic              step_s;
    logic              match_s;

    // Right shift with the XOR of the tapped bits entering at the MSB.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
        return {^(cur & TAPS), cur[WIDTH-1:1]};
    endfunction

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; any load (even a rejected one) suppresses stepping that cycle.
    always_comb begin
        state_nxt_s = state_r;
        step_s      = 1'b0;
        load_ok_s   = load && (seed != {WIDTH{1'b0}});
        load_bad_s  = load && (seed == {WIDTH{1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (load_ok_s) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READY: begin
                if (load) begin
                    state_nxt_s = ST_READY;
                end else if (run) begin
                    state_nxt_s = ST_RUN;
                    step_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_RUN: begin
                if (load_ok_s) begin
                    state_nxt_s = ST_READY;
                end else if (load_bad_s) begin
                    state_nxt_s = ST_RUN;
                end else if (run) begin
                    state_nxt_s = ST_RUN;
                    step_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Feedback value, period match and saturating counter increment.
    always_comb begin
        q_nxt_s = lfsr_next(q_r);
        match_s = step_s && (q_nxt_s == seed_cap_r);
        if (cnt_r == {CW{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // LFSR state, captured seed, step counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r           <= {WIDTH{1'b0}};
            seed_cap_r    <= {WIDTH{1'b0}};
            cnt_r         <= {CW{1'b0}};
            period_r      <= {CW{1'b0}};
            sel_r         <= 1'b0;
            running_r     <= 1'b0;
            period_done_r <= 1'b0;
            seed_err_r    <= 1'b0;
        end else begin
            running_r     <= (state_nxt_s == ST_RUN);
            sel_r         <= (state_nxt_s == ST_RUN);
            period_done_r <= match_s;
            if (load_ok_s) begin
                q_r        <= seed;
                seed_cap_r <= seed;
                cnt_r      <= {CW{1'b0}};
                seed_err_r <= 1'b0;
            end else if (load_bad_s) begin
                seed_err_r <= 1'b1;
            end else if (step_s) begin
                q_r <= q_nxt_s;
                if (match_s) begin
                    cnt_r    <= {CW{1'b0}};
                    period_r <= cnt_inc_s;
                end else begin
                    cnt_r    <= cnt_inc_s;
                end
            end
        end
    end

    assign q           = q_r;
    assign sel         = sel_r;
    assign running     = running_r;
    assign period_done = period_done_r;
    assign period      = period_r;
    assign seed_err    = seed_err_r;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Directed self-checking bench for lfsr_step_ctrl (WIDTH=4, TAPS=4'b0011, CW=5).
module tb_lfsr_step_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] seed;
    logic       load;
    logic       run;
    logic [3:0] q;
    logic       sel;
    logic       running;
    logic       period_done;
    logic [4:0] period;
    logic       seed_err;

    int n_total = 0;
    int n_bad   = 0;

    // Hand-derived maximal sequence starting from 4'b1000; entry i is the state after i steps.
    logic [3:0] seq [0:14] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                               4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

    lfsr_step_ctrl #(.WIDTH(4), .TAPS(4'b0011), .CW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seed        (seed),
        .load        (load),
        .run         (run),
        .q           (q),
        .sel         (sel),
        .running     (running),
        .period_done (period_done),
        .period      (period),
        .seed_err    (seed_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_q"},        32'(q),           32'h0);
        chk({tag, "_sel"},      32'(sel),         32'h0);
        chk({tag, "_running"},  32'(running),     32'h0);
        chk({tag, "_pdone"},    32'(period_done), 32'h0);
        chk({tag, "_period"},   32'(period),      32'h0);
        chk({tag, "_seed_err"}, 32'(seed_err),    32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        seed  = 4'h0;
        load  = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Load 1000 without run.
        seed = 4'b1000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("ld_q",        32'(q),        32'h8);
        chk("ld_running",  32'(running),  32'h0);
        chk("ld_sel",      32'(sel),      32'h0);
        chk("ld_seed_err", 32'(seed_err), 32'h0);
        @(negedge clk);
        chk("ready_hold_q", 32'(q), 32'h8);

        // Free run for two full periods.
        run = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk($sformatf("run_q_%0d", k),     32'(q),           32'(seq[k % 15]));
            chk($sformatf("run_pdone_%0d", k), 32'(period_done), 32'((k % 15) == 0));
            if (k == 1) begin
                chk("run_sel",     32'(sel),     32'h1);
                chk("run_running", 32'(running), 32'h1);
            end
        end
        chk("run_period", 32'(period), 32'd15);

        // Asynchronous reset in RUN, then run held high in IDLE.
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst1");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_run_q",       32'(q),       32'h0);
        chk("idle_run_running", 32'(running), 32'h0);

        // Zero seed is rejected in IDLE.
        seed = 4'h0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("zero_seed_err", 32'(seed_err), 32'h1);
        chk("zero_q",        32'(q),        32'h0);
        repeat (3) @(negedge clk);
        chk("zero_run_q",       32'(q),       32'h0);
        chk("zero_run_running", 32'(running), 32'h0);
        chk("zero_err_sticky",  32'(seed_err), 32'h1);

        // Valid load clears the error.
        run  = 1'b0;
        seed = 4'b0001;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("reload_seed_err", 32'(seed_err), 32'h0);
        chk("reload_q",        32'(q),        32'h1);

        // Five steps, pause for four cycles, then finish the period.
        run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("pre_q_%0d", k), 32'(q), 32'(seq[(14 + k) % 15]));
        end
        run = 1'b0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            chk($sformatf("pause_q_%0d", p),   32'(q),       32'hC);
            chk($sformatf("pause_run_%0d", p), 32'(running), 32'h0);
            chk($sformatf("pause_sel_%0d", p), 32'(sel),     32'h0);
        end
        run = 1'b1;
        for (int k = 6; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("post_q_%0d", k),     32'(q),           32'(seq[(14 + k) % 15]));
            chk($sformatf("post_pdone_%0d", k), 32'(period_done), 32'(k == 15));
        end
        chk("pause_period", 32'(period), 32'd15);
        repeat (2) @(negedge clk);
        chk("post_extra_q", 32'(q), 32'(seq[1]));

        // Load together with run mid-RUN: load wins, sequence restarts.
        seed = 4'b1111;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("lr_q",       32'(q),           32'hF);
        chk("lr_running", 32'(running),     32'h0);
        chk("lr_sel",     32'(sel),         32'h0);
        chk("lr_pdone",   32'(period_done), 32'h0);
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            chk($sformatf("lr_q_%0d", j),     32'(q),           32'(seq[(11 + j) % 15]));
            chk($sformatf("lr_pdone_%0d", j), 32'(period_done), 32'(j == 15));
        end
        chk("lr_period", 32'(period), 32'd15);

        // Reset pulse mid-RUN must act before the next clock edge.
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst2");
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("final_q", 32'(q), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
